// File: rtl/int_to_float_seq.sv
// Sequential signed int32 -> IEEE-754 single converter, one normalise step per cycle, RNE rounding.
// Optional FP_CVT_INEXACT_EN adds the inexact_o flag (G|S of the discarded bits).
module int_to_float_seq #(
  parameter int NORM_STEP = 1
) (
  input  logic        clk_i,
  input  logic        rst_b_i,
  input  logic        start_i,
  input  logic [31:0] in_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] out_o
`ifdef FP_CVT_INEXACT_EN
  , output logic      inexact_o
`endif
);

  typedef enum logic {IDLE, NORM} state_t;

  localparam logic [7:0] STEP_E = 8'(NORM_STEP);

  state_t      state_q;
  logic        sign_q;
  logic [31:0] mag_q;
  logic [7:0]  exp_q;
  logic        busy_q, done_q;
  logic [31:0] out_q;

  // Rounding datapath, only meaningful once mag_q[31] is set.
  logic [22:0] frac_w;
  logic        g_w, s_w, up_w;
  logic [23:0] sum_w;
  logic [7:0]  rexp_w;
  logic [31:0] rnd_w;

  always_comb begin
    frac_w = mag_q[30:8];
    g_w    = mag_q[7];
    s_w    = |mag_q[6:0];
    up_w   = g_w & (s_w | frac_w[0]);
    sum_w  = {1'b0, frac_w} + {23'd0, up_w};
    rexp_w = exp_q + {7'd0, sum_w[23]};
    rnd_w  = {sign_q, rexp_w, sum_w[22:0]};
  end

`ifdef FP_CVT_INEXACT_EN
  logic inexact_q;
  assign inexact_o = inexact_q;
`endif

  always_ff @(posedge clk_i) begin
    if (!rst_b_i) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
`ifdef FP_CVT_INEXACT_EN
      inexact_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            sign_q  <= in_i[31];
            // 0x80000000 negates to itself, which is exactly 2^31 unsigned.
            mag_q   <= in_i[31] ? (~in_i + 32'd1) : in_i;
            exp_q   <= 8'd158;
            out_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= NORM;
`ifdef FP_CVT_INEXACT_EN
            inexact_q <= 1'b0;
`endif
          end
        end
        NORM: begin
          if (mag_q == '0) begin
            out_q   <= '0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else if (mag_q[31]) begin
            out_q   <= rnd_w;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
`ifdef FP_CVT_INEXACT_EN
            inexact_q <= g_w | s_w;
`endif
          end else if (mag_q[31 -: NORM_STEP] == '0) begin
            mag_q <= mag_q << NORM_STEP;
            exp_q <= exp_q - STEP_E;
          end else begin
            mag_q <= mag_q << 1;
            exp_q <= exp_q - 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign out_o  = out_q;

endmodule

// File: tb/tb_int_to_float_seq.sv
// Scoreboard bench for int_to_float_seq: directed vectors queue expected results, a monitor checks on done.
module tb_int_to_float_seq;

  logic        clk = 1'b0;
  logic        rst_b;
  logic        start, start8;
  logic [31:0] din, din8;
  logic        busy, done, busy8, done8;
  logic [31:0] dout, dout8;
  logic        inx, inx8;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int_to_float_seq #(.NORM_STEP(1)) dut (
    .clk_i(clk), .rst_b_i(rst_b), .start_i(start), .in_i(din),
    .busy_o(busy), .done_o(done), .out_o(dout)
`ifdef FP_CVT_INEXACT_EN
    , .inexact_o(inx)
`endif
  );

  int_to_float_seq #(.NORM_STEP(8)) dut8 (
    .clk_i(clk), .rst_b_i(rst_b), .start_i(start8), .in_i(din8),
    .busy_o(busy8), .done_o(done8), .out_o(dout8)
`ifdef FP_CVT_INEXACT_EN
    , .inexact_o(inx8)
`endif
  );

`ifndef FP_CVT_INEXACT_EN
  assign inx  = 1'b0;
  assign inx8 = 1'b0;
`endif

  typedef struct {
    logic [31:0] o;
    logic        ix;
    int          lat;
    int          c0;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (busy && done) chk("busy_done_overlap", 32'(busy & done), 32'd0);
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out", dout, e.o);
        chk("latency", 32'(cyc - e.c0), 32'(e.lat));
`ifdef FP_CVT_INEXACT_EN
        chk("inexact", 32'(inx), 32'(e.ix));
`endif
      end
    end
  end

  // Called at a negedge; leaves start low at the following negedge.
  task automatic issue(input logic [31:0] v, input logic [31:0] o, input logic ix, input int lat);
    exp_t e;
    e.o = o; e.ix = ix; e.lat = lat; e.c0 = cyc;
    sb.push_back(e);
    start = 1'b1;
    din   = v;
    @(negedge clk);
    start = 1'b0;
    din   = 32'hDEAD_BEEF;
  endtask

  // Returns at the negedge where done is seen, so the next issue is back-to-back.
  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [31:0] v;
    logic [31:0] o;
    logic        ix;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  initial begin
    // lat = 2 + shift cycles, counted from the negedge where start is driven
    vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 1'b0, 33});
    vecs.push_back('{32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 33});
    vecs.push_back('{32'h0000_0000, 32'h0000_0000, 1'b0, 2});
    vecs.push_back('{32'h8000_0000, 32'hCF00_0000, 1'b0, 2});
    vecs.push_back('{32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 3});
    vecs.push_back('{32'h0100_0001, 32'h4B80_0000, 1'b1, 9});
    vecs.push_back('{32'h0100_0003, 32'h4B80_0002, 1'b1, 9});
    vecs.push_back('{32'h0000_0064, 32'h42C8_0000, 1'b0, 27});
    vecs.push_back('{32'hFFFF_FFF8, 32'hC100_0000, 1'b0, 30});

    rst_b = 1'b0; start = 1'b0; start8 = 1'b0; din = '0; din8 = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_out", dout, 32'd0);
    chk("reset_inexact", 32'(inx), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);

    // Each start lands in the cycle the previous done is high.
    foreach (vecs[i]) begin
      issue(vecs[i].v, vecs[i].o, vecs[i].ix, vecs[i].lat);
      wait_done();
    end
    @(negedge clk);
    chk("out_held", dout, 32'hC100_0000);

    // A start during NORM must be ignored: same result and latency as a lone in=1.
    issue(32'h0000_0001, 32'h3F80_0000, 1'b0, 33);
    repeat (4) @(negedge clk);
    start = 1'b1; din = 32'h0000_0005;
    @(negedge clk);
    start = 1'b0;
    chk("busy_mid", 32'(busy), 32'd1);
    wait_done();
    @(negedge clk);

    // Reset mid-NORM abandons the conversion with no done.
    start = 1'b1; din = 32'h0000_0001;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst_b = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_out", dout, 32'd0);
    rst_b = 1'b1;
    repeat (40) @(negedge clk);

    // NORM_STEP=8: in=1 takes 3 wide + 7 single shifts.
    begin
      int c0, n;
      c0 = cyc;
      start8 = 1'b1; din8 = 32'h0000_0001;
      @(negedge clk);
      start8 = 1'b0;
      n = 0;
      while (!done8 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("step8_done", 32'(done8), 32'd1);
      chk("step8_out", dout8, 32'h3F80_0000);
      chk("step8_latency", 32'(cyc - c0), 32'd12);
    end

    repeat (2) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
